// File: rtl/vec_mul_pkg.sv
// vec_mul_pkg: shared types and defaults for the Vedic multiplier lane and its consumers.
package vec_mul_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} acc_state_e;
    localparam logic [1:0] PREC_8BIT = 2'b00;
    localparam int DEF_ACC_WIDTH = 48;
    localparam int DEF_LEN_WIDTH = 8;
endpackage

// File: rtl/split_acc_adder.sv
// split_acc_adder: ACC_WIDTH adder whose carry chain can be broken at the midpoint.
module split_acc_adder #(
    parameter int ACC_WIDTH = 48
) (
    input  logic [ACC_WIDTH-1:0] a,
    input  logic [ACC_WIDTH-1:0] b,
    input  logic                 split,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 carry_lo,
    output logic                 carry_hi
);
    localparam int H = ACC_WIDTH / 2;
    logic [H:0] lo;
    logic [ACC_WIDTH-H:0] hi;
    always_comb begin
        lo = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]};
        hi = {1'b0, a[ACC_WIDTH-1:H]} + {1'b0, b[ACC_WIDTH-1:H]} + {{(ACC_WIDTH-H){1'b0}}, lo[H] & ~split};
        sum = {hi[ACC_WIDTH-H-1:0], lo[H-1:0]};
        carry_lo = lo[H];
        carry_hi = hi[ACC_WIDTH-H];
    end
endmodule

// File: rtl/vec_dot_accumulator.sv
// vec_dot_accumulator: accumulates vec_len multiplier products into a dot-product result
// in either one full-width lane or two independent half-width lanes.
module vec_dot_accumulator
    import vec_mul_pkg::*;
#(
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] vec_len,
    input  logic [1:0]           precision,
    input  logic                 prod_valid,
    input  logic [31:0]          prod_data,
    output logic                 busy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ACC_WIDTH-1:0] res_data,
    output logic                 overflow
);
    localparam int H = ACC_WIDTH / 2;
    acc_state_e state_q;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d, len_q;
    logic [ACC_WIDTH-1:0] acc_q, acc_d, operand;
    logic split_q, ovf_q, busy_q, res_valid_q, carry_lo, carry_hi, carry_d, take_start;

    // In split mode each 16-bit lane product is zero-extended into its own half.
    assign operand = split_q ? {{(H-16){1'b0}}, prod_data[31:16], {(ACC_WIDTH-H-16){1'b0}}, prod_data[15:0]}
                             : {{(ACC_WIDTH-32){1'b0}}, prod_data};
    assign cnt_d = cnt_q + LEN_WIDTH'(1);
    assign carry_d = split_q ? (carry_lo | carry_hi) : carry_hi;
    assign take_start = start && (state_q == IDLE || (state_q == DONE && res_ready));

    split_acc_adder #(.ACC_WIDTH(ACC_WIDTH)) u_add (
        .a(acc_q),
        .b(operand),
        .split(split_q),
        .sum(acc_d),
        .carry_lo(carry_lo),
        .carry_hi(carry_hi)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            len_q <= '0;
            split_q <= 1'b0;
            acc_q <= '0;
            ovf_q <= 1'b0;
            busy_q <= 1'b0;
            res_valid_q <= 1'b0;
        end else if (take_start) begin
            state_q <= (vec_len == '0) ? DONE : ACCUM;
            cnt_q <= '0;
            len_q <= vec_len;
            split_q <= (precision == PREC_8BIT);
            acc_q <= '0;
            ovf_q <= 1'b0;
            busy_q <= 1'b1;
            res_valid_q <= (vec_len == '0);
        end else if (state_q == ACCUM && prod_valid) begin
            acc_q <= acc_d;
            ovf_q <= ovf_q | carry_d;
            cnt_q <= cnt_d;
            state_q <= (cnt_d == len_q) ? DONE : ACCUM;
            res_valid_q <= (cnt_d == len_q);
        end else if (state_q == DONE && res_ready) begin
            state_q <= IDLE;
            busy_q <= 1'b0;
            res_valid_q <= 1'b0;
        end
    end

    assign busy = busy_q;
    assign res_valid = res_valid_q;
    assign res_data = acc_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_vec_dot_accumulator.sv
// tb_vec_dot_accumulator: directed checks of the dot-product accumulator at 48-bit and 34-bit widths.
module tb_vec_dot_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [7:0] vec_len = '0;
    logic [1:0] precision = 2'b01;
    logic prod_valid = 1'b0;
    logic [31:0] prod_data = '0;
    logic res_ready = 1'b0;
    logic busy, res_valid, overflow;
    logic [47:0] res_data;
    logic busy_s, res_valid_s, overflow_s;
    logic [33:0] res_data_s;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vec_dot_accumulator #(.ACC_WIDTH(48), .LEN_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .precision(precision),
        .prod_valid(prod_valid), .prod_data(prod_data), .busy(busy), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .overflow(overflow)
    );

    vec_dot_accumulator #(.ACC_WIDTH(34), .LEN_WIDTH(8)) dut_s (
        .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .precision(precision),
        .prod_valid(prod_valid), .prod_data(prod_data), .busy(busy_s), .res_valid(res_valid_s),
        .res_ready(res_ready), .res_data(res_data_s), .overflow(overflow_s)
    );

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic b, input logic v, input logic [47:0] d, input logic o);
        chk({tag, "_busy"}, {47'd0, busy}, {47'd0, b});
        chk({tag, "_valid"}, {47'd0, res_valid}, {47'd0, v});
        chk({tag, "_data"}, res_data, d);
        chk({tag, "_ovf"}, {47'd0, overflow}, {47'd0, o});
    endtask

    initial begin
        #1;
        chk_out("reset", 1'b0, 1'b0, 48'h0, 1'b0);
        chk("reset_s_data", {14'd0, res_data_s}, 48'h0);
        cyc();
        rst = 1'b1;
        cyc();

        // 16-bit run; precision flips mid-run and must be ignored
        start = 1'b1; vec_len = 8'd3; precision = 2'b01;
        cyc();
        start = 1'b0;
        chk_out("t1_started", 1'b1, 1'b0, 48'h0, 1'b0);
        prod_valid = 1'b1; prod_data = 32'h0000_FFFF;
        cyc();
        precision = 2'b00; prod_data = 32'h0001_0000;
        cyc();
        chk("t1_not_yet", {47'd0, res_valid}, 48'h0);
        prod_data = 32'h0000_0001;
        cyc();
        prod_valid = 1'b0;
        chk_out("t1_result", 1'b1, 1'b1, 48'h0000_0002_0000, 1'b0);
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
        chk_out("t1_idle", 1'b0, 1'b0, 48'h0000_0002_0000, 1'b0);

        // packed 8-bit lanes
        start = 1'b1; vec_len = 8'd2; precision = 2'b00;
        cyc();
        start = 1'b0; prod_valid = 1'b1; prod_data = 32'hFFFF_FFFF;
        cyc();
        cyc();
        prod_valid = 1'b0;
        chk_out("t2_lanes", 1'b1, 1'b1, 48'h01FFFE_01FFFE, 1'b0);
        chk("t2_lanes_s", {14'd0, res_data_s}, 48'h3_FFFD_FFFE);
        chk("t2_ovf_s", {47'd0, overflow_s}, 48'h0);
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;

        // overflow: wraps at 34 bits, fits at 48
        start = 1'b1; vec_len = 8'd5; precision = 2'b10;
        cyc();
        start = 1'b0; prod_valid = 1'b1; prod_data = 32'hFFFF_FFFF;
        repeat (5) cyc();
        prod_valid = 1'b0;
        chk("t3_data_s", {14'd0, res_data_s}, 48'h0_FFFF_FFFB);
        chk("t3_ovf_s", {47'd0, overflow_s}, 48'h1);
        chk("t3_valid_s", {47'd0, res_valid_s}, 48'h1);
        chk_out("t3_wide", 1'b1, 1'b1, 48'h4_FFFF_FFFB, 1'b0);
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;

        // zero length
        start = 1'b1; vec_len = 8'd0; precision = 2'b01;
        cyc();
        start = 1'b0;
        chk_out("t4_zero", 1'b1, 1'b1, 48'h0, 1'b0);
        chk("t4_zero_s_ovf", {47'd0, overflow_s}, 48'h0);
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;

        // start during ACCUM is ignored
        start = 1'b1; vec_len = 8'd4;
        cyc();
        start = 1'b0; prod_valid = 1'b1; prod_data = 32'd1;
        cyc();
        start = 1'b1; vec_len = 8'd1; prod_data = 32'd2;
        cyc();
        start = 1'b0; prod_data = 32'd3;
        cyc();
        chk("t4_ign_not_yet", {47'd0, res_valid}, 48'h0);
        prod_data = 32'd4;
        cyc();
        chk_out("t4_ign_result", 1'b1, 1'b1, 48'd10, 1'b0);

        // back-pressure: extra products dropped, result held
        prod_data = 32'h100;
        for (int i = 0; i < 5; i++) begin
            prod_valid = i[0];
            cyc();
            chk("t5_hold_data", res_data, 48'd10);
            chk("t5_hold_valid", {47'd0, res_valid}, 48'h1);
        end
        prod_valid = 1'b0;

        // back-to-back start with handshake
        res_ready = 1'b1; start = 1'b1; vec_len = 8'd2; precision = 2'b01;
        cyc();
        res_ready = 1'b0; start = 1'b0;
        chk_out("t5_b2b", 1'b1, 1'b0, 48'h0, 1'b0);
        prod_valid = 1'b1; prod_data = 32'd7;
        cyc();
        prod_data = 32'd8;
        cyc();
        prod_valid = 1'b0;
        chk_out("t5_second", 1'b1, 1'b1, 48'd15, 1'b0);
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;

        // asynchronous reset mid-run
        start = 1'b1; vec_len = 8'd4;
        cyc();
        start = 1'b0; prod_valid = 1'b1; prod_data = 32'd5;
        cyc();
        prod_data = 32'd6;
        cyc();
        prod_valid = 1'b0;
        chk("t6_partial", res_data, 48'd11);
        rst = 1'b0;
        #1;
        chk_out("t6_reset", 1'b0, 1'b0, 48'h0, 1'b0);
        cyc();
        rst = 1'b1;
        cyc();
        chk_out("t6_idle", 1'b0, 1'b0, 48'h0, 1'b0);
        start = 1'b1; vec_len = 8'd2;
        cyc();
        start = 1'b0; prod_valid = 1'b1; prod_data = 32'd3;
        cyc();
        prod_data = 32'd4;
        cyc();
        prod_valid = 1'b0;
        chk_out("t6_fresh", 1'b1, 1'b1, 48'd7, 1'b0);
        chk("t6_fresh_s", {14'd0, res_data_s}, 48'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
